// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: byte-masked write port, two read ports,
// bulk-clear request and status strobes.
interface reg_file_2r1w_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                 we;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WIDTH/8-1:0]   wr_be;
    logic [WIDTH-1:0]     wr_data;
    logic                 rd_en_a;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [WIDTH-1:0]     rd_data_a;
    logic                 rd_valid_a;
    logic                 rd_en_b;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic [WIDTH-1:0]     rd_data_b;
    logic                 rd_valid_b;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;
    logic                 wr_drop;

    modport master (
        output we, wr_addr, wr_be, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        input  busy, clr_done, wr_drop
    );

    modport slave (
        input  we, wr_addr, wr_be, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        output busy, clr_done, wr_drop
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte enables, write-to-read bypass,
// optional hardwired zero entry and a sequenced bulk-clear engine.
module reg_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_2r1w_if.slave bus
);
    localparam int NB = WIDTH / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              clr_done_q;
    logic              wr_drop_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd_data_a_q;
    logic [WIDTH-1:0]  rd_data_b_q;
    logic              rd_valid_a_q;
    logic              rd_valid_b_q;

    logic              sweep_s;
    logic              wr_in_range_s;
    logic              wr_zero_s;
    logic              wr_accept_s;
    logic              wr_drop_d;
    logic [WIDTH-1:0]  wr_old_s;
    logic [WIDTH-1:0]  wr_merged_s;
    logic [WIDTH-1:0]  stored_a_s;
    logic [WIDTH-1:0]  stored_b_s;
    logic [WIDTH-1:0]  rd_data_a_d;
    logic [WIDTH-1:0]  rd_data_b_d;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(DEPTH));
    endfunction

    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
            else       res[8*k +: 8] = old_v[8*k +: 8];
        end
        return res;
    endfunction

    // Priority: out-of-range and zero entry read 0, then the entry being swept,
    // then a same-edge accepted write merged over the stored value.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              sweep,
        input logic [ADDR_W-1:0] sweep_addr,
        input logic              wr_acc,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata,
        input logic [NB-1:0]     wbe
    );
        logic [WIDTH-1:0] res;
        if (!in_range(addr))                                 res = {WIDTH{1'b0}};
        else if (ZERO_REG && (addr == {ADDR_W{1'b0}}))       res = {WIDTH{1'b0}};
        else if (sweep && (addr == sweep_addr))              res = {WIDTH{1'b0}};
        else if (wr_acc && (addr == waddr))                  res = byte_merge(stored, wdata, wbe);
        else                                                 res = stored;
        return res;
    endfunction

    // Write acceptance, drop detection and read-data selection.
    always_comb begin
        sweep_s       = (state_q == ST_CLEAR);
        wr_in_range_s = in_range(bus.wr_addr);
        wr_zero_s     = ZERO_REG && (bus.wr_addr == {ADDR_W{1'b0}});
        wr_accept_s   = bus.we && !busy_q && wr_in_range_s && !wr_zero_s;
        wr_drop_d     = bus.we && (|bus.wr_be) && (busy_q || !wr_in_range_s);
        wr_old_s      = wr_in_range_s ? mem_q[bus.wr_addr] : {WIDTH{1'b0}};
        wr_merged_s   = byte_merge(wr_old_s, bus.wr_data, bus.wr_be);
        stored_a_s    = in_range(bus.rd_addr_a) ? mem_q[bus.rd_addr_a] : {WIDTH{1'b0}};
        stored_b_s    = in_range(bus.rd_addr_b) ? mem_q[bus.rd_addr_b] : {WIDTH{1'b0}};
        rd_data_a_d   = read_mux(bus.rd_addr_a, stored_a_s, sweep_s, cnt_q,
                                 wr_accept_s, bus.wr_addr, bus.wr_data, bus.wr_be);
        rd_data_b_d   = read_mux(bus.rd_addr_b, stored_b_s, sweep_s, cnt_q,
                                 wr_accept_s, bus.wr_addr, bus.wr_data, bus.wr_be);
    end

    // Entry storage: reset wipe, sweep clear, byte-masked write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
        end else if (sweep_s) begin
            mem_q[cnt_q] <= {WIDTH{1'b0}};
        end else if (wr_accept_s) begin
            mem_q[bus.wr_addr] <= wr_merged_s;
        end
    end

    // Registered read ports and write-drop strobe; data holds when not read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q  <= {WIDTH{1'b0}};
            rd_data_b_q  <= {WIDTH{1'b0}};
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            rd_valid_a_q <= bus.rd_en_a;
            rd_valid_b_q <= bus.rd_en_b;
            if (bus.rd_en_a) rd_data_a_q <= rd_data_a_d;
            if (bus.rd_en_b) rd_data_b_q <= rd_data_b_d;
            wr_drop_q    <= wr_drop_d;
        end
    end

    // Bulk-clear sequencer: one entry per cycle, done pulse on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (bus.clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= {ADDR_W{1'b0}};
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= {ADDR_W{1'b0}};
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= {ADDR_W{1'b0}};
                    busy_q     <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data_a  = rd_data_a_q;
    assign bus.rd_valid_a = rd_valid_a_q;
    assign bus.rd_data_b  = rd_data_b_q;
    assign bus.rd_valid_b = rd_valid_b_q;
    assign bus.busy       = busy_q;
    assign bus.clr_done   = clr_done_q;
    assign bus.wr_drop    = wr_drop_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w (DEPTH=24, ZERO_REG=1) with hand-computed expectations.
module tb_reg_file_2r1w;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 24;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   busy_cnt;
    int   done_cnt;

    reg_file_2r1w_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file_2r1w #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.wr_addr = 5'd0; bus.wr_be = 4'h0; bus.wr_data = 32'h0;
        bus.rd_en_a = 1'b0; bus.rd_addr_a = 5'd0;
        bus.rd_en_b = 1'b0; bus.rd_addr_b = 5'd0;
        bus.clr_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.we = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    endtask

    task automatic rda(input logic [4:0] a);
        bus.rd_en_a = 1'b1; bus.rd_addr_a = a;
    endtask

    task automatic rdb(input logic [4:0] a);
        bus.rd_en_b = 1'b1; bus.rd_addr_b = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); wr(5'(i), 32'(i + 1), 4'hF); tick();
        end
        idle();
    endtask

    initial begin
        total = 0; bad = 0;
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_valid_a", {31'd0, bus.rd_valid_a}, 32'd0);
        chk("reset_data_a", bus.rd_data_a, 32'h0);
        chk("reset_clr_done", {31'd0, bus.clr_done}, 32'd0);
        chk("reset_wr_drop", {31'd0, bus.wr_drop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reads straight out of reset
        idle(); rda(5'd5); rdb(5'd31); tick();
        chk("rd_a5_data", bus.rd_data_a, 32'h0);
        chk("rd_a5_valid", {31'd0, bus.rd_valid_a}, 32'd1);
        chk("rd_b31_data", bus.rd_data_b, 32'h0);
        chk("rd_b31_valid", {31'd0, bus.rd_valid_b}, 32'd1);

        // Byte-enable write, then read on both ports
        idle(); wr(5'd3, 32'hAABBCCDD, 4'b1111); tick();
        chk("wr3_no_drop", {31'd0, bus.wr_drop}, 32'd0);
        chk("idle_valid_a", {31'd0, bus.rd_valid_a}, 32'd0);
        idle(); wr(5'd3, 32'h11223344, 4'b0101); tick();
        idle(); rda(5'd3); rdb(5'd3); tick();
        chk("be_merge_a", bus.rd_data_a, 32'hAA22CC44);
        chk("be_merge_b", bus.rd_data_b, 32'hAA22CC44);
        idle(); tick();
        chk("hold_data_a", bus.rd_data_a, 32'hAA22CC44);

        // Bypass on port A, port B unaffected
        idle(); wr(5'd7, 32'hDEADBEEF, 4'b0011); rda(5'd7); rdb(5'd6); tick();
        chk("bypass_a7", bus.rd_data_a, 32'h0000BEEF);
        chk("bypass_b6", bus.rd_data_b, 32'h0);
        idle(); rda(5'd7); tick();
        chk("stored_a7", bus.rd_data_a, 32'h0000BEEF);
        idle(); wr(5'd3, 32'h55000000, 4'b1000); rdb(5'd3); tick();
        chk("bypass_merge_b3", bus.rd_data_b, 32'h5522CC44);

        // Legal no-op write
        idle(); wr(5'd3, 32'hFFFFFFFF, 4'b0000); tick();
        chk("be0_no_drop", {31'd0, bus.wr_drop}, 32'd0);
        idle(); rda(5'd3); tick();
        chk("be0_unchanged", bus.rd_data_a, 32'h5522CC44);

        // Zero register and out-of-range
        idle(); wr(5'd0, 32'hFFFFFFFF, 4'hF); rda(5'd0); tick();
        chk("zero_bypass", bus.rd_data_a, 32'h0);
        chk("zero_no_drop", {31'd0, bus.wr_drop}, 32'd0);
        idle(); rda(5'd0); tick();
        chk("zero_read", bus.rd_data_a, 32'h0);
        idle(); wr(5'd30, 32'h12345678, 4'hF); tick();
        chk("oor_drop", {31'd0, bus.wr_drop}, 32'd1);
        idle(); rda(5'd30); tick();
        chk("oor_drop_clear", {31'd0, bus.wr_drop}, 32'd0);
        chk("oor_read", bus.rd_data_a, 32'h0);
        chk("oor_valid", {31'd0, bus.rd_valid_a}, 32'd1);

        // Bulk clear with a write on the request edge
        fill();
        idle(); bus.clr_req = 1'b1; wr(5'd2, 32'h00000077, 4'hF); tick();
        chk("clr_busy_rise", {31'd0, bus.busy}, 32'd1);
        chk("clr_req_wr_ok", {31'd0, bus.wr_drop}, 32'd0);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (k == 1) rda(5'd2);
            if (k == 3) wr(5'd10, 32'h00000BAD, 4'hF);
            if (k == 5) begin rda(5'd4); rdb(5'd5); end
            if (k == 6) rda(5'd10);
            if (k == 8) begin rda(5'd20); rdb(5'd9); end
            if (bus.busy) busy_cnt++;
            tick();
            if (bus.clr_done) done_cnt++;
            if (k == 1) chk("sweep_unswept_2", bus.rd_data_a, 32'h00000077);
            if (k == 3) chk("busy_wr_drop", {31'd0, bus.wr_drop}, 32'd1);
            if (k == 5) begin
                chk("sweep_swept_4", bus.rd_data_a, 32'h0);
                chk("sweep_bypass_5", bus.rd_data_b, 32'h0);
            end
            if (k == 6) chk("busy_wr_ignored", bus.rd_data_a, 32'd11);
            if (k == 8) begin
                chk("sweep_old_20", bus.rd_data_a, 32'd21);
                chk("sweep_old_9", bus.rd_data_b, 32'd10);
            end
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            idle(); rda(5'(i)); tick();
            chk($sformatf("post_clr_%0d", i), bus.rd_data_a, 32'h0);
        end

        // Reset in the middle of a sweep
        fill();
        idle(); bus.clr_req = 1'b1; tick();
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            idle(); tick();
            if (bus.clr_done) done_cnt++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.clr_done}, 32'd0);
        #1 rst_n = 1'b1;
        idle(); rda(5'd20); rdb(5'd15); tick();
        if (bus.clr_done) done_cnt++;
        chk("midrst_entry20", bus.rd_data_a, 32'h0);
        chk("midrst_entry15", bus.rd_data_b, 32'h0);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        idle(); bus.clr_req = 1'b1; tick();
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (bus.busy) busy_cnt++;
            tick();
            if (bus.clr_done) done_cnt++;
        end
        chk("reclr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        chk("reclr_done_pulses", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised successor to the team's single-port register file. Provides one write port with byte enables and two independent registered read ports, with write-to-read bypass and an optional hardwired zero entry. Includes a sequenced bulk-clear engine for software-initiated wipes without asserting reset. Used as the architectural register store in the datapath.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8.
DEPTH, 32, number of entries, 2..256; need not be a power of two.
ADDR_W, $clog2(DEPTH), address width.
ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
we  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_be  in  WIDTH/8  byte enables; bit k covers data[8k+7:8k]
wr_data  in  WIDTH  write data
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read address, port A
rd_data_a  out  WIDTH  read data, port A
rd_valid_a  out  1  rd_data_a valid strobe
rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: same as port A, port B
clr_req  in  1  start bulk clear (pulse)
busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse when clear completes
wr_drop  out  1  one-cycle pulse: a write was discarded

Behaviour:
- Reset (rst_n=0, asynchronous): all entries = 0, rd_data_a/b = 0, rd_valid_a/b = 0, busy = 0, clr_done = 0, wr_drop = 0, FSM = IDLE, clear counter = 0.
- Write: on the edge with we=1, each byte of wr_addr with wr_be[k]=1 takes wr_data; bytes with wr_be[k]=0 are unchanged. we=1 with wr_be=0 is a legal no-op, no wr_drop.
- Write discarded, with wr_drop=1 the next cycle, when: wr_addr >= DEPTH; busy=1. A write to entry 0 with ZERO_REG=1 is silently ignored (no wr_drop).
- Read: registered, latency 1. rd_en_x=1 at edge N gives rd_data_x and rd_valid_x=1 after edge N. rd_en_x=0 gives rd_valid_x=0 after the edge, and rd_data_x holds its previous value.
- Bypass: a read and an accepted write to the same address at the same edge return merged data. Enabled bytes come from wr_data; other bytes come from the stored entry. Both ports bypass independently.
- Read of address >= DEPTH returns 0, valid=1. Read of entry 0 with ZERO_REG=1 returns 0 regardless of bypass.
- Both ports may read the same address in the same cycle; both return identical data.
- Clear FSM, two states:
  - IDLE: clr_req=1 goes to CLEAR with counter=0 and busy=1 from the next cycle.
  - CLEAR: each cycle, entry[counter] = 0 and counter increments. On the edge clearing entry DEPTH-1, go to IDLE, busy=0, clr_done=1 for one cycle.
  - A clear takes exactly DEPTH cycles of busy=1.
- clr_req in CLEAR is ignored; no restart.
- Reads remain serviced during CLEAR. An entry not yet swept returns its old value; an entry already swept returns 0. A read of the entry being cleared at that edge returns 0 (clear bypass).
- A write arriving on the same edge as clr_req (in IDLE) is accepted. That entry is later swept to 0.
- rst_n asserted mid-clear: immediate return to IDLE with all entries 0; no clr_done pulse.

Test Plan:
- Reset then read: deassert rst_n; read A addr 5, read B addr 31 -> both rd_data=0x0, rd_valid=1 one cycle later.
- Byte-enable write: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 3 = 0xAA22CC44.
- Bypass: addr 7 holds 0x0; same cycle write 0xDEADBEEF be=4'b0011 to addr 7 and read A addr 7 -> rd_data_a=0x0000BEEF next cycle. Read B addr 6 in the same cycle is unaffected.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> read addr 0 = 0, wr_drop=0. Out of range (DEPTH=24): write to addr 30 -> wr_drop=1; read addr 30 = 0.
- Bulk clear: fill all entries with index+1, pulse clr_req -> busy=1 for exactly DEPTH cycles, clr_done=1 once. A write during busy gives wr_drop=1. Mid-sweep reads return 0 for swept entries and index+1 for the rest. All entries are 0 after clr_done.
- Reset mid-clear: assert rst_n low at sweep cycle 10 -> busy=0 at once, all entries 0, no clr_done; a following clr_req runs a full clear normally.
